// File: rtl/mem_pkg.sv
// ============================================================
// mem_pkg: shared FSM states, response codes and parity helper
// Rev 1.0
// ============================================================
`default_nettype none

package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DEC  = 3'd1,
      ST_ACC  = 3'd2,
      ST_RESP = 3'd3,
      ST_REJ  = 3'd4,
      ST_HOLD = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_OK   = 2'd1,
      RSP_EN   = 2'd2,
      RSP_PE   = 2'd3
   } rsp_e;

   function automatic logic par16(input logic [15:0] d);
      return ^d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================
// mem_array: 2**AW x 17-bit sync RAM (data + parity), read latency 1
// Rev 1.0
// ============================================================
`default_nettype none

module mem_array #(
   parameter int AW = 12
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [16:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [16:0]   rdata_o
);

   logic [16:0] mem_q [2**AW];
   logic [16:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================
// mem_bus_responder: bus memory slave answering OK/EN/PE, 4-phase handshake
// Rev 1.0
// ============================================================
`default_nettype none

module mem_bus_responder
   import mem_pkg::*;
#(
   parameter logic [3:0] NB_SEL  = 4'd0,
   parameter logic [3:0] MOD_SEL = 4'd0,
   parameter int         AW      = 12
) (
   input  logic        __clk,
   input  logic        __rst,
   input  logic        r_,
   input  logic        w_,
   input  logic [3:0]  nb,
   input  logic [15:0] ad,
   input  logic [15:0] dt_in,
   input  logic        inj_pe,
   output logic [15:0] dt_out,
   output logic        ok_,
   output logic        en_,
   output logic        pe_,
   output logic        busy
);

   localparam logic [12:0] c_words = 13'(2**AW);

   state_e      state_q, state_d;
   rsp_e        rsp_q, w_rsp;
   logic [2:0]  rd_sync_q, wr_sync_q;
   logic        cmd_rd_q, cmd_wr_q;
   logic [11:0] ad_q;
   logic [15:0] dt_q, dout_q, w_dout;
   logic        inj_q, inj_d, ign_q, ign_d;
   logic [16:0] w_rdata;

   // [1] is the synchronised level, [2] the same level one cycle earlier
   wire w_rd_req   = ~rd_sync_q[1] & ~rd_sync_q[2];
   wire w_wr_req   = ~wr_sync_q[1] & ~wr_sync_q[2];
   wire w_any_req  = w_rd_req | w_wr_req;
   wire w_released = rd_sync_q[1] & wr_sync_q[1];
   wire w_match    = (nb == NB_SEL) && (ad[15:12] == MOD_SEL);
   wire w_addr_ok  = {1'b0, ad_q} < c_words;
   wire w_we       = (state_q == ST_ACC) && cmd_wr_q;
   wire w_re       = (state_q == ST_ACC) && cmd_rd_q;

   always_comb begin
      state_d = state_q;
      ign_d   = ign_q;
      inj_d   = inj_q | inj_pe;
      unique case (state_q)
         ST_IDLE: begin
            if (w_any_req && w_match && !ign_q) begin
               state_d = ST_DEC;
            end
         end
         ST_DEC:  state_d = ((cmd_rd_q ^ cmd_wr_q) && w_addr_ok) ? ST_ACC : ST_REJ;
         ST_ACC:  state_d = ST_RESP;
         ST_RESP: state_d = ST_HOLD;
         ST_REJ:  state_d = ST_HOLD;
         ST_HOLD: begin
            if (w_released) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // a foreign request is shadowed until it releases, even if nb/ad change meanwhile
      if (state_q == ST_IDLE && w_any_req && !w_match) begin
         ign_d = 1'b1;
      end else if (w_released) begin
         ign_d = 1'b0;
      end
      if (w_we) begin
         inj_d = 1'b0;
      end
   end

   always_comb begin
      w_rsp  = RSP_NONE;
      w_dout = 16'h0000;
      unique case (state_q)
         ST_RESP: begin
            if (cmd_rd_q) begin
               w_dout = w_rdata[15:0];
               w_rsp  = (par16(w_rdata[15:0]) == w_rdata[16]) ? RSP_OK : RSP_PE;
            end else begin
               w_rsp = RSP_OK;
            end
         end
         ST_REJ:  w_rsp = RSP_EN;
         ST_HOLD: begin
            w_rsp  = rsp_q;
            w_dout = dout_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge __clk) begin
      if (__rst) begin
         state_q   <= ST_IDLE;
         rsp_q     <= RSP_NONE;
         dout_q    <= 16'h0000;
         rd_sync_q <= 3'b111;
         wr_sync_q <= 3'b111;
         inj_q     <= 1'b0;
         ign_q     <= 1'b0;
         cmd_rd_q  <= 1'b0;
         cmd_wr_q  <= 1'b0;
         ad_q      <= 12'h000;
         dt_q      <= 16'h0000;
      end else begin
         state_q   <= state_d;
         rd_sync_q <= {rd_sync_q[1:0], r_};
         wr_sync_q <= {wr_sync_q[1:0], w_};
         inj_q     <= inj_d;
         ign_q     <= ign_d;
         if (state_q == ST_IDLE && state_d == ST_DEC) begin
            cmd_rd_q <= w_rd_req;
            cmd_wr_q <= w_wr_req;
            ad_q     <= ad[11:0];
            dt_q     <= dt_in;
         end
         if (state_q == ST_RESP || state_q == ST_REJ) begin
            rsp_q  <= w_rsp;
            dout_q <= w_dout;
         end
      end
   end

   mem_array #(.AW(AW)) u_array (
      .clk_i   (__clk),
      .we_i    (w_we),
      .waddr_i (ad_q[AW-1:0]),
      .wdata_i ({par16(dt_q) ^ inj_q, dt_q}),
      .re_i    (w_re),
      .raddr_i (ad_q[AW-1:0]),
      .rdata_o (w_rdata)
   );

   assign ok_    = (w_rsp != RSP_OK);
   assign en_    = (w_rsp != RSP_EN);
   assign pe_    = (w_rsp != RSP_PE);
   assign dt_out = w_dout;
   assign busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
// ============================================================
// tb_mem_bus_responder: directed scoreboard bench for mem_bus_responder
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_n = 1'b1;
   logic        w_n = 1'b1;
   logic [3:0]  nb = 4'd0;
   logic [15:0] ad = 16'h0000;
   logic [15:0] dt_in = 16'h0000;
   logic        inj = 1'b0;
   logic [15:0] dt_out;
   logic        ok_o, en_o, pe_o, busy;

   always #5 clk = ~clk;

   mem_bus_responder #(.NB_SEL(4'd3), .MOD_SEL(4'd0), .AW(10)) dut (
      .__clk  (clk),
      .__rst  (rst),
      .r_     (r_n),
      .w_     (w_n),
      .nb     (nb),
      .ad     (ad),
      .dt_in  (dt_in),
      .inj_pe (inj),
      .dt_out (dt_out),
      .ok_    (ok_o),
      .en_    (en_o),
      .pe_    (pe_o),
      .busy   (busy)
   );

   int cyc = 0;
   int total = 0;
   int bad = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  oep;   // {ok_, en_, pe_}
      logic [15:0] dt;
      int          t0;
      int          lat;
   } exp_t;
   exp_t sbq[$];

   // monitor: on every fresh response, pop and compare against the scoreboard
   logic act_prev = 1'b0;
   logic act;
   always @(negedge clk) begin
      act = ({ok_o, en_o, pe_o} != 3'b111);
      if (act && !act_prev) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp: got oep=%b dt=%h with nothing expected", {ok_o, en_o, pe_o}, dt_out);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if ({ok_o, en_o, pe_o} !== e.oep || dt_out !== e.dt || (cyc - e.t0) != e.lat) begin
               bad++;
               $display("FAIL resp: got oep=%b dt=%h lat=%0d, want oep=%b dt=%h lat=%0d",
                        {ok_o, en_o, pe_o}, dt_out, cyc - e.t0, e.oep, e.dt, e.lat);
            end
         end
      end
      act_prev = act;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic access(input bit rd, input bit wr, input logic [3:0] nbv, input logic [15:0] adv,
                         input logic [15:0] dv, input bit resp, input logic [2:0] oep,
                         input logic [15:0] edt, input int lat);
      exp_t e;
      int   n;
      @(negedge clk);
      if (resp) begin
         e.oep = oep; e.dt = edt; e.t0 = cyc; e.lat = lat;
         sbq.push_back(e);
      end
      nb = nbv; ad = adv; dt_in = dv; r_n = !rd; w_n = !wr;
      if (resp) begin
         n = 0;
         while ({ok_o, en_o, pe_o} == 3'b111 && n < 20) begin
            @(negedge clk); n++;
         end
         repeat (3) @(negedge clk);
         check("held", {12'h0, oep, 1'b0, edt}, {12'h0, ok_o, en_o, pe_o, 1'b0, dt_out});
         r_n = 1'b1; w_n = 1'b1;
         n = 0;
         while (({ok_o, en_o, pe_o} != 3'b111 || busy) && n < 10) begin
            @(negedge clk); n++;
         end
         check("release_lat", n, 3);
         check("idle_after", {ok_o, en_o, pe_o, busy, dt_out}, {3'b111, 1'b0, 16'h0000});
      end else begin
         n = 0;
         repeat (12) begin
            @(negedge clk);
            if ({ok_o, en_o, pe_o} != 3'b111 || busy) n++;
         end
         check("ignored", n, 0);
         r_n = 1'b1; w_n = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      int n;
      exp_t e;
      repeat (2) @(negedge clk);
      check("reset_state", {ok_o, en_o, pe_o, busy, dt_out}, {3'b111, 1'b0, 16'h0000});
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // write then read back
      access(0, 1, 4'd3, 16'h0010, 16'hA5C3, 1, 3'b011, 16'h0000, 6);
      access(1, 0, 4'd3, 16'h0010, 16'h0000, 1, 3'b011, 16'hA5C3, 6);
      // wrong block number / wrong module number: ignored
      access(1, 0, 4'd5, 16'h0010, 16'h0000, 0, 3'b111, 16'h0000, 0);
      access(1, 0, 4'd3, 16'h1010, 16'h0000, 0, 3'b111, 16'h0000, 0);
      // beyond implemented space, and last implemented word
      access(1, 0, 4'd3, 16'h0400, 16'h0000, 1, 3'b101, 16'h0000, 5);
      access(0, 1, 4'd3, 16'h03FF, 16'h7E81, 1, 3'b011, 16'h0000, 6);
      access(1, 0, 4'd3, 16'h03FF, 16'h0000, 1, 3'b011, 16'h7E81, 6);
      // read+write together refused, storage untouched
      access(0, 1, 4'd3, 16'h0020, 16'h1234, 1, 3'b011, 16'h0000, 6);
      access(1, 1, 4'd3, 16'h0020, 16'hFFFF, 1, 3'b101, 16'h0000, 5);
      access(1, 0, 4'd3, 16'h0020, 16'h0000, 1, 3'b011, 16'h1234, 6);
      // injected parity error, then a clean rewrite
      @(negedge clk); inj = 1'b1;
      @(negedge clk); inj = 1'b0;
      access(0, 1, 4'd3, 16'h0030, 16'h0001, 1, 3'b011, 16'h0000, 6);
      access(1, 0, 4'd3, 16'h0030, 16'h0000, 1, 3'b110, 16'h0001, 6);
      access(0, 1, 4'd3, 16'h0030, 16'h0001, 1, 3'b011, 16'h0000, 6);
      access(1, 0, 4'd3, 16'h0030, 16'h0000, 1, 3'b011, 16'h0001, 6);

      // one-cycle glitch on r_
      @(negedge clk); nb = 4'd3; ad = 16'h0010; r_n = 1'b0;
      @(negedge clk); r_n = 1'b1;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if ({ok_o, en_o, pe_o} != 3'b111 || busy) n++;
      end
      check("glitch", n, 0);

      // reset while holding a write response
      @(negedge clk);
      e.oep = 3'b011; e.dt = 16'h0000; e.t0 = cyc; e.lat = 6;
      sbq.push_back(e);
      nb = 4'd3; ad = 16'h0040; dt_in = 16'hBEEF; w_n = 1'b0;
      n = 0;
      while ({ok_o, en_o, pe_o} == 3'b111 && n < 20) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      check("hold_before_rst", {ok_o, busy}, {1'b0, 1'b1});
      rst = 1'b1; w_n = 1'b1;
      @(negedge clk);
      check("rst_in_hold", {ok_o, en_o, pe_o, busy, dt_out}, {3'b111, 1'b0, 16'h0000});
      rst = 1'b0;
      repeat (3) @(negedge clk);
      access(1, 0, 4'd3, 16'h0040, 16'h0000, 1, 3'b011, 16'hBEEF, 6);

      check("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
